// File: rtl/input_memory_pkg.sv
// Shared constants and helpers for the input_memory block: default widths,
// words per packed write, address width, the operation decode type and the
// read-address helper.
package input_memory_pkg;

   localparam int unsigned DATA_WIDTH_DEF  = 128;
   localparam int unsigned WORD_WIDTH_DEF  = 32;
   localparam int unsigned DEPTH_DEF       = 32;
   localparam int unsigned WORDS_PER_WRITE = 4;
   localparam int unsigned ADDR_WIDTH      = $clog2(DEPTH_DEF);

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   // Decoded per-cycle operation of the memory.
   typedef enum logic [1:0] {
      OP_HOLD   = 2'd0,   // block disabled, nothing changes
      OP_WRITE4 = 2'd1,   // normal packed write of four words
      OP_WRITE1 = 2'd2,   // final write of a frame, low word only
      OP_READ   = 2'd3    // registered single-word read
   } op_e;

   // Read address = kernel offset + window offset, summed 5 bits wide so
   // that 15+15 cannot overflow.
   function automatic addr_t rd_addr(input logic [3:0] mul_shift,
                                     input logic [3:0] accu_shift);
      logic [4:0] sum;
      sum = {1'b0, mul_shift} + {1'b0, accu_shift};
      return addr_t'(sum);
   endfunction

endpackage

// File: rtl/input_memory_if.sv
// Bus interface of input_memory. The optional Data_valid signal exists only
// when INPUT_MEMORY_RD_VALID_EN is defined.
interface input_memory_if
   import input_memory_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) ();

   logic [DATA_WIDTH-1:0] Data_In;
   logic                  Write_En;
   logic                  En;
   logic                  Last_Address;
   logic [3:0]            mul_shift;
   logic [3:0]            accu_shift;
   logic [WORD_WIDTH-1:0] Data_out;
`ifdef INPUT_MEMORY_RD_VALID_EN
   logic                  Data_valid;
`endif

   // Driver side (producer of writes and read addresses).
   modport master (
      output Data_In, Write_En, En, Last_Address, mul_shift, accu_shift,
`ifdef INPUT_MEMORY_RD_VALID_EN
      input  Data_valid,
`endif
      input  Data_out
   );

   // Memory side.
   modport slave (
      input  Data_In, Write_En, En, Last_Address, mul_shift, accu_shift,
`ifdef INPUT_MEMORY_RD_VALID_EN
      output Data_valid,
`endif
      output Data_out
   );

endinterface

// File: rtl/input_memory.sv
// input_memory: word-addressed frame buffer. Packed four-word writes fill
// consecutive entries from an internal write pointer; reads return one word
// at (mul_shift + accu_shift) with one cycle of latency. Whole state is
// cleared by the asynchronous reset.
// Optional feature: define INPUT_MEMORY_RD_VALID_EN to add Data_valid.
module input_memory
   import input_memory_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
   parameter int unsigned DEPTH      = DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input_memory_if.slave bus
);

   logic [DATA_WIDTH-1:0] din_s;
   addr_t                 rd_addr_s;
   op_e                   op_s;

   logic [WORD_WIDTH-1:0] mem_q [DEPTH];
   logic [WORD_WIDTH-1:0] mem_d [DEPTH];
   addr_t                 wp_q, wp_d;
   logic [WORD_WIDTH-1:0] dout_q, dout_d;
`ifdef INPUT_MEMORY_RD_VALID_EN
   logic                  valid_q, valid_d;
`endif

   assign din_s     = bus.Data_In;
   assign rd_addr_s = rd_addr(bus.mul_shift, bus.accu_shift);

   // Decode the control inputs into one operation; En gates everything.
   always_comb begin
      op_s = OP_HOLD;
      if (!bus.En) begin
         op_s = OP_HOLD;
      end else if (bus.Write_En) begin
         op_s = bus.Last_Address ? OP_WRITE4 : OP_WRITE1;
      end else begin
         op_s = OP_READ;
      end
   end

   // Next-state for storage, write pointer and read register; addresses wrap
   // naturally in the ADDR_WIDTH-bit pointer arithmetic.
   always_comb begin
      mem_d  = mem_q;
      wp_d   = wp_q;
      dout_d = dout_q;
`ifdef INPUT_MEMORY_RD_VALID_EN
      valid_d = 1'b0;
`endif
      case (op_s)
         OP_WRITE4: begin
            for (int k = 0; k < int'(WORDS_PER_WRITE); k++) begin
               mem_d[wp_q + addr_t'(k)] = din_s[k*WORD_WIDTH +: WORD_WIDTH];
            end
            wp_d = wp_q + addr_t'(WORDS_PER_WRITE);
         end
         OP_WRITE1: begin
            mem_d[wp_q] = din_s[WORD_WIDTH-1:0];
            wp_d        = '0;   // frame complete, next frame starts at 0
         end
         OP_READ: begin
            dout_d = mem_q[rd_addr_s];
`ifdef INPUT_MEMORY_RD_VALID_EN
            valid_d = 1'b1;
`endif
         end
         default: begin
            dout_d = dout_q;
         end
      endcase
   end

   // State registers with asynchronous clear of memory, pointer and output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wp_q   <= '0;
         dout_q <= '0;
`ifdef INPUT_MEMORY_RD_VALID_EN
         valid_q <= 1'b0;
`endif
      end else begin
         mem_q  <= mem_d;
         wp_q   <= wp_d;
         dout_q <= dout_d;
`ifdef INPUT_MEMORY_RD_VALID_EN
         valid_q <= valid_d;
`endif
      end
   end

   assign bus.Data_out = dout_q;
`ifdef INPUT_MEMORY_RD_VALID_EN
   assign bus.Data_valid = valid_q;
`endif

endmodule

// File: tb/tb_input_memory.sv
// Self-checking bench for input_memory: table of directed vectors for the
// frame load and read sweep, then hand-written sequences for hold, wrap and
// asynchronous reset. Data_valid is checked when INPUT_MEMORY_RD_VALID_EN
// is defined.
module tb_input_memory;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   input_memory_if bus ();

   input_memory dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         en;
      logic         we;
      logic         last;
      logic [3:0]   mul;
      logic [3:0]   accu;
      logic [127:0] din;
      logic         chk;
      logic [31:0]  exp;
   } vec_t;

   vec_t vecs[$];
   int   shift_set [9];

   // Known word stored at entry e during the frame load.
   function automatic logic [31:0] ev(input int e);
      logic [7:0] b;
      b = e[7:0];
      return {16'hC0DE, b, ~b};
   endfunction

   // Word k of packed frame f in the wrap test.
   function automatic logic [31:0] wv(input int f, input int k);
      logic [7:0] fb;
      logic [7:0] kb;
      fb = f[7:0];
      kb = k[7:0];
      return {16'h5000, fb, kb};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic drive(input logic en, input logic we, input logic last,
                        input logic [3:0] mul, input logic [3:0] accu,
                        input logic [127:0] din);
      bus.En           = en;
      bus.Write_En     = we;
      bus.Last_Address = last;
      bus.mul_shift    = mul;
      bus.accu_shift   = accu;
      bus.Data_In      = din;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [3:0] m, input logic [3:0] a, input string name,
                     input logic [31:0] exp);
      drive(1'b1, 1'b0, 1'b1, m, a, 128'd0);
      tick();
      check(name, bus.Data_out, exp);
`ifdef INPUT_MEMORY_RD_VALID_EN
      check({name, "_valid"}, {31'd0, bus.Data_valid}, 32'd1);
`endif
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 128'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("reset_dout", bus.Data_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      vec_t v;
      total = 0;
      bad   = 0;
      shift_set = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

      // ---- build vector table: frame load then read sweep ----
      for (int f = 0; f < 6; f++) begin
         v = '{en: 1'b1, we: 1'b1, last: 1'b1, mul: 4'd0, accu: 4'd0,
               din: {ev(4*f+3), ev(4*f+2), ev(4*f+1), ev(4*f)},
               chk: 1'b0, exp: 32'd0};
         vecs.push_back(v);
      end
      v = '{en: 1'b1, we: 1'b1, last: 1'b0, mul: 4'd0, accu: 4'd0,
            din: {96'hDEAD_BEEF_1234_5678_9ABC_DEF0, ev(24)},
            chk: 1'b0, exp: 32'd0};
      vecs.push_back(v);
      foreach (shift_set[i]) begin
         foreach (shift_set[j]) begin
            v = '{en: 1'b1, we: 1'b0, last: 1'b1,
                  mul: 4'(shift_set[i]), accu: 4'(shift_set[j]),
                  din: 128'd0, chk: 1'b1,
                  exp: ev(shift_set[i] + shift_set[j])};
            vecs.push_back(v);
         end
      end
      // Entry 25 lies past the final low-word write and must still be 0.
      v = '{en: 1'b1, we: 1'b0, last: 1'b1, mul: 4'd13, accu: 4'd12,
            din: 128'd0, chk: 1'b1, exp: 32'd0};
      vecs.push_back(v);

      // ---- reset state ----
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 128'd0);
      #1;
      check("reset_init", bus.Data_out, 32'd0);
`ifdef INPUT_MEMORY_RD_VALID_EN
      check("reset_valid", {31'd0, bus.Data_valid}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // ---- apply table ----
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].en, vecs[i].we, vecs[i].last, vecs[i].mul, vecs[i].accu, vecs[i].din);
         tick();
         if (vecs[i].chk) begin
            check($sformatf("vec%0d", i), bus.Data_out, vecs[i].exp);
         end
`ifdef INPUT_MEMORY_RD_VALID_EN
         check($sformatf("vec%0d_valid", i), {31'd0, bus.Data_valid}, {31'd0, vecs[i].chk});
`endif
      end

      // ---- hold behaviour: En=0 and write cycles keep Data_out ----
      rd(4'd12, 4'd12, "frame_last", ev(24));
      rd(4'd1, 4'd2, "pre_hold", ev(3));
      drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, {4{32'hFFFF_FFFF}});
      tick();
      check("en0_write_hold", bus.Data_out, ev(3));
`ifdef INPUT_MEMORY_RD_VALID_EN
      check("en0_valid", {31'd0, bus.Data_valid}, 32'd0);
`endif
      drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 128'd0);
      tick();
      check("en0_read_hold", bus.Data_out, ev(3));
      drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000});
      tick();
      check("wr_hold", bus.Data_out, ev(3));
`ifdef INPUT_MEMORY_RD_VALID_EN
      check("wr_valid", {31'd0, bus.Data_valid}, 32'd0);
`endif
      rd(4'd0, 4'd0, "wp_kept0", 32'h7777_0000);
      rd(4'd2, 4'd1, "wp_kept3", 32'h7777_0003);
      rd(4'd4, 4'd0, "en0_no_write", ev(4));

      // ---- write pointer wraps modulo depth ----
      do_reset();
      for (int f = 0; f < 9; f++) begin
         drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, {wv(f, 3), wv(f, 2), wv(f, 1), wv(f, 0)});
         tick();
      end
      rd(4'd0, 4'd0, "wrap_e0", wv(8, 0));
      rd(4'd1, 4'd2, "wrap_e3", wv(8, 3));
      rd(4'd4, 4'd0, "wrap_e4", wv(1, 0));
      rd(4'd15, 4'd13, "wrap_e28", wv(7, 0));
      rd(4'd15, 4'd15, "wrap_e30", wv(7, 2));

      // ---- asynchronous reset between edges ----
      drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 128'd0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_dout", bus.Data_out, 32'd0);
`ifdef INPUT_MEMORY_RD_VALID_EN
      check("async_rst_valid", {31'd0, bus.Data_valid}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      rd(4'd15, 4'd15, "post_rst_e30", 32'd0);
      rd(4'd0, 4'd4, "post_rst_e4", 32'd0);
      drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, {32'hAB00_0003, 32'hAB00_0002, 32'hAB00_0001, 32'hAB00_0000});
      tick();
      rd(4'd0, 4'd1, "post_rst_wp0", 32'hAB00_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/input_memory.md
INPUT_MEMORY -- requirements
Module: input_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 128, meaning write-bus width (four packed words).
REQ-002 Parameter WORD_WIDTH, default 32, meaning stored/read word width.
REQ-003 Parameter DEPTH, default 32, meaning number of WORD_WIDTH entries; address width clog2(DEPTH)=5.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 Data_In  input  DATA_WIDTH  write data; word k at bits [32k+31:32k], k=0..3.
REQ-007 Write_En  input  1  1 = write cycle, 0 = read cycle (qualified by En).
REQ-008 En  input  1  block enable; no state changes when 0.
REQ-009 Last_Address  input  1  0 = final write of a frame (low word only); 1 = normal 4-word write.
REQ-010 mul_shift  input  4  kernel (multiplier) offset component of read address.
REQ-011 accu_shift  input  4  window (accumulator) offset component of read address.
REQ-012 Data_out  output  WORD_WIDTH  registered read data.

Function
REQ-013 Internal write pointer wp (5 bits) SHALL select the first entry of each write.
REQ-014 En=1, Write_En=1, Last_Address=1: mem[wp+k] <= Data_In word k for k=0..3; wp <= wp+4.
REQ-015 En=1, Write_En=1, Last_Address=0: mem[wp] <= Data_In[31:0] only; wp <= 0 (frame done).
REQ-016 Write addresses wp+k and wp+4 SHALL wrap modulo DEPTH.
REQ-017 En=1, Write_En=0: Data_out <= mem[mul_shift + accu_shift], sum computed 5 bits wide (max 30, no overflow).
REQ-018 Read latency one cycle: value visible immediately after the rising edge sampling the address.
REQ-019 Data_out SHALL hold its value during write cycles and while En=0.
REQ-020 En=0: memory, wp, Data_out unchanged regardless of other inputs.
REQ-021 Read of an entry in the same cycle it is written cannot occur (write and read are exclusive via Write_En).

Reset
REQ-022 rst=1 SHALL asynchronously clear wp, Data_out and all memory entries to 0.
REQ-023 Reset mid-frame SHALL abandon the frame; next write starts at entry 0.
REQ-024 Reset deassertion takes effect on the next clk rising edge; no other reset source.

Configuration
REQ-025 Macro INPUT_MEMORY_RD_VALID_EN defined: extra output Data_valid (1 bit) SHALL be 1 the cycle after a read cycle, 0 otherwise, reset 0.
REQ-026 Macro undefined: no Data_valid port; all other behaviour identical.

Structure
REQ-027 Shared package SHALL hold DATA_WIDTH, WORD_WIDTH, DEPTH defaults, WORDS_PER_WRITE=4 and address-width constant.
REQ-028 Single module; storage array inline, no sub-module.

Verification
REQ-029 Reset, then 6 writes Last_Address=1 of random data D0..D5 plus one write Last_Address=0 of D6 -> entries 0..23 = packed words, entry 24 = D6[31:0], wp=0.
REQ-030 After REQ-029 load, read mul_shift=12, accu_shift=12 -> Data_out = D6[31:0] after next edge.
REQ-031 Sweep mul_shift in {0,1,2,5,6,7,10,11,12} x accu_shift same set -> Data_out = entry (mul+accu) every read, one-cycle latency.
REQ-032 En=0 with Write_En=1 and new Data_In -> memory and Data_out unchanged.
REQ-033 Assert rst asynchronously between clock edges mid-read -> Data_out=0 immediately; subsequent read of any address returns 0.
REQ-034 With INPUT_MEMORY_RD_VALID_EN: read cycle -> Data_valid=1 for exactly one cycle; write cycle -> Data_valid=0.
